// File: rtl/ip_pkg.sv
// ip_pkg: shared definitions for the input-peripheral scan controller.
//   - LSU register addresses (byte addresses, decoded on [15:2])
//   - scan FSM state encoding
//   - CTRL bit positions, reset value and writable-bit mask
//   - addr_hit(): word-address compare helper
package ip_pkg;

  localparam logic [15:0] IP_SW_ADDR   = 16'h7800;
  localparam logic [15:0] IP_BTN_ADDR  = 16'h7810;
  localparam logic [15:0] IP_EVT_ADDR  = 16'h7814;
  localparam logic [15:0] IP_CTRL_ADDR = 16'h7818;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_COMMIT = 2'd3
  } scan_state_e;

  localparam int CTRL_SCAN_EN_BIT = 0;
  localparam int CTRL_IRQ_EN_BIT  = 1;
  localparam int CTRL_MASK_LSB    = 4;
  localparam int CTRL_MASK_MSB    = 7;

  localparam logic [7:0] CTRL_RST_VAL = 8'hF1;
  // Only scan_en, irq_en and irq_mask are implemented; other bits read 0.
  localparam logic [7:0] CTRL_WR_MASK = 8'hF3;

  // Byte-lane bits [1:0] and the region bits [31:16] are don't-care.
  function automatic logic addr_hit(input logic [15:0] addr, input logic [15:0] reg_addr);
    return addr[15:2] == reg_addr[15:2];
  endfunction

endpackage

// File: rtl/ip_scan_ctrl_if.sv
// ip_scan_ctrl_if: LSU register-port bundle.
//   i_lsu_addr  LSU byte address
//   i_lsu_wren  write enable
//   i_st_data   store data
//   o_rdata     combinational read data
// Handshake: there is no valid/ready pair. A write is accepted on every rising
// clock edge where i_lsu_wren is high; reads are combinational from the current
// registers and need no strobe, so the port can never stall.
interface ip_scan_ctrl_if;
  logic [31:0] i_lsu_addr;
  logic        i_lsu_wren;
  logic [31:0] i_st_data;
  logic [31:0] o_rdata;

  modport master (output i_lsu_addr, output i_lsu_wren, output i_st_data, input o_rdata);
  modport slave  (input i_lsu_addr, input i_lsu_wren, input i_st_data, output o_rdata);
endinterface

// File: rtl/ip_debounce_bit.sv
// ip_debounce_bit: one input bit of the scan controller.
//   i_clk, i_rst  clock, synchronous active-low reset
//   i_raw         asynchronous pin
//   i_hold        scanning disabled: clear the agreement counter
//   i_sample      evaluate the counter and compute the next stable value
//   i_commit      load the next stable value into o_stable
//   o_stable      debounced value
//   o_next        stable value computed in the last sample pass
module ip_debounce_bit #(
  parameter int STABLE_SAMPLES = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  input  logic i_hold,
  input  logic i_sample,
  input  logic i_commit,
  output logic o_stable,
  output logic o_next
);

  localparam logic [2:0] CNT_LAST = 3'(STABLE_SAMPLES - 1);

  logic       sync1_q, sync2_q;
  logic [2:0] cnt_q;
  logic       next_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_raw;
      sync2_q <= sync1_q;
    end
  end

  // The flip needs STABLE_SAMPLES differing samples in a row: the counter
  // already holding CNT_LAST means this sample is the last one required.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt_q  <= 3'd0;
      next_q <= 1'b0;
    end else if (i_hold) begin
      cnt_q  <= 3'd0;
      next_q <= o_stable;
    end else if (i_sample) begin
      if (sync2_q != o_stable) begin
        if (cnt_q == CNT_LAST) begin
          cnt_q  <= 3'd0;
          next_q <= sync2_q;
        end else begin
          cnt_q  <= cnt_q + 3'd1;
          next_q <= o_stable;
        end
      end else begin
        cnt_q  <= 3'd0;
        next_q <= o_stable;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst)        o_stable <= 1'b0;
    else if (i_commit) o_stable <= next_q;
  end

  assign o_next = next_q;

endmodule

// File: rtl/ip_scan_ctrl.sv
// ip_scan_ctrl: switch/button scan controller for the input-peripheral region.
//   i_clk, i_rst   clock, synchronous active-low reset
//   i_io_sw        32 raw switch pins
//   i_io_btn       4 raw button pins (1 = pressed)
//   bus            LSU register port (EVT at 0x7814, CTRL at 0x7818)
//   o_sw_state     debounced switches
//   o_btn_state    debounced buttons
//   o_upd_en       one-cycle strobe when the debounced state changed
//   o_irq          level interrupt: irq_en & |(EVT & irq_mask)
//   o_dbg_state    current scan FSM state
module ip_scan_ctrl
  import ip_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          STABLE_SAMPLES  = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [31:0]   i_io_sw,
  input  logic [3:0]    i_io_btn,
  ip_scan_ctrl_if.slave bus,
  output logic [31:0]   o_sw_state,
  output logic [3:0]    o_btn_state,
  output logic          o_upd_en,
  output logic          o_irq,
  output scan_state_e   o_dbg_state
);

  scan_state_e state_q, state_d;
  logic [15:0] presc_q;
  logic        presc_tc;
  logic        presc_run, hold_en, sample_en, commit_en;
  logic [35:0] raw_vec, stable_vec, next_vec;
  logic [3:0]  evt_q, evt_set, evt_clr, btn_rise;
  logic [7:0]  ctrl_q;
  logic        scan_en, irq_en;
  logic        wr_evt, wr_ctrl;
  logic        upd_q;
  logic        unused_bits;

  assign scan_en = ctrl_q[CTRL_SCAN_EN_BIT];
  assign irq_en  = ctrl_q[CTRL_IRQ_EN_BIT];
  assign wr_evt  = bus.i_lsu_wren && addr_hit(bus.i_lsu_addr[15:0], IP_EVT_ADDR);
  assign wr_ctrl = bus.i_lsu_wren && addr_hit(bus.i_lsu_addr[15:0], IP_CTRL_ADDR);
  assign unused_bits = ^{bus.i_lsu_addr[31:16], bus.i_lsu_addr[1:0], bus.i_st_data[31:8]};

  assign raw_vec = {i_io_btn, i_io_sw};

  for (genvar g = 0; g < 36; g++) begin : g_bit
    ip_debounce_bit #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_bit (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_raw    (raw_vec[g]),
      .i_hold   (hold_en),
      .i_sample (sample_en),
      .i_commit (commit_en),
      .o_stable (stable_vec[g]),
      .o_next   (next_vec[g])
    );
  end

  // FSM: state register
  always_ff @(posedge i_clk) begin
    if (!i_rst) state_q <= S_WAIT;
    else        state_q <= state_d;
  end

  assign presc_tc = (presc_q == DEBOUNCE_CYCLES - 16'd1);

  // FSM: next state. SAMPLE/COMMIT always finish their pass before IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (scan_en) state_d = S_WAIT;
      S_WAIT: begin
        if (!scan_en)      state_d = S_IDLE;
        else if (presc_tc) state_d = S_SAMPLE;
      end
      S_SAMPLE: state_d = S_COMMIT;
      S_COMMIT: state_d = scan_en ? S_WAIT : S_IDLE;
      default:  state_d = S_WAIT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    presc_run = 1'b0;
    hold_en   = 1'b0;
    sample_en = 1'b0;
    commit_en = 1'b0;
    case (state_q)
      S_IDLE:   hold_en   = 1'b1;
      S_WAIT:   presc_run = scan_en && !presc_tc;
      S_SAMPLE: sample_en = 1'b1;
      S_COMMIT: commit_en = 1'b1;
      default:  ;
    endcase
  end

  // Prescaler is zero whenever it is not actively counting inside WAIT.
  always_ff @(posedge i_clk) begin
    if (!i_rst)         presc_q <= 16'd0;
    else if (presc_run) presc_q <= presc_q + 16'd1;
    else                presc_q <= 16'd0;
  end

  // Strobe lines up with the registered stable state one cycle after COMMIT.
  always_ff @(posedge i_clk) begin
    if (!i_rst) upd_q <= 1'b0;
    else        upd_q <= commit_en && |(next_vec ^ stable_vec);
  end

  assign btn_rise = next_vec[35:32] & ~stable_vec[35:32];
  assign evt_set  = commit_en ? btn_rise : 4'd0;
  assign evt_clr  = wr_evt ? bus.i_st_data[3:0] : 4'd0;

  // Set after clear so a simultaneous press and W1C keeps the event.
  always_ff @(posedge i_clk) begin
    if (!i_rst) evt_q <= 4'd0;
    else        evt_q <= (evt_q & ~evt_clr) | evt_set;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst)       ctrl_q <= CTRL_RST_VAL;
    else if (wr_ctrl) ctrl_q <= bus.i_st_data[7:0] & CTRL_WR_MASK;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) o_irq <= 1'b0;
    else        o_irq <= irq_en && |(evt_q & ctrl_q[CTRL_MASK_MSB:CTRL_MASK_LSB]);
  end

  always_comb begin
    bus.o_rdata = 32'd0;
    if (addr_hit(bus.i_lsu_addr[15:0], IP_EVT_ADDR))       bus.o_rdata = {28'd0, evt_q};
    else if (addr_hit(bus.i_lsu_addr[15:0], IP_CTRL_ADDR)) bus.o_rdata = {24'd0, ctrl_q};
  end

  assign o_sw_state  = stable_vec[31:0];
  assign o_btn_state = stable_vec[35:32];
  assign o_upd_en    = upd_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_ip_scan_ctrl.sv
// tb_ip_scan_ctrl: directed bench for ip_scan_ctrl with DEBOUNCE_CYCLES = 4,
// STABLE_SAMPLES = 3 (scan loop period 6 cycles). Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_ip_scan_ctrl;
  import ip_pkg::*;

  localparam logic [31:0] EVT_A  = 32'h0000_7814;
  localparam logic [31:0] CTRL_A = 32'h0000_7818;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] io_sw = 32'd0;
  logic [3:0]  io_btn = 4'd0;
  logic [31:0] sw_state;
  logic [3:0]  btn_state;
  logic        upd_en, irq;
  scan_state_e dbg_state;

  always #5 clk = ~clk;

  ip_scan_ctrl_if bus ();

  ip_scan_ctrl #(.DEBOUNCE_CYCLES(16'd4), .STABLE_SAMPLES(3)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_io_sw     (io_sw),
    .i_io_btn    (io_btn),
    .bus         (bus.slave),
    .o_sw_state  (sw_state),
    .o_btn_state (btn_state),
    .o_upd_en    (upd_en),
    .o_irq       (irq),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int upd_cnt = 0;
  int consec  = 0;
  logic prev_upd = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (upd_en) upd_cnt++;
    if (upd_en && prev_upd) consec++;
    prev_upd = upd_en;
  end

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.i_lsu_addr = a;
    bus.i_st_data  = d;
    bus.i_lsu_wren = 1'b1;
    @(negedge clk);
    bus.i_lsu_wren = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.i_lsu_addr = a;
    #1;
    d = bus.o_rdata;
  endtask

  task automatic wait_upd(input string tag, input int bound, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < bound) begin
      @(negedge clk);
      n++;
      if (upd_en) seen = 1'b1;
    end
    check_eq({tag, "_strobe"}, 32'(seen), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    int n, base, ns;
    bit seen;

    bus.i_lsu_addr = 32'd0;
    bus.i_st_data  = 32'd0;
    bus.i_lsu_wren = 1'b0;

    // Reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check_eq("rst_sw", sw_state, 32'd0);
    check_eq("rst_btn", {28'd0, btn_state}, 32'd0);
    check_eq("rst_upd", {31'd0, upd_en}, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    check_eq("rst_fsm", {30'd0, dbg_state}, {30'd0, S_WAIT});
    base = upd_cnt;
    repeat (50) @(negedge clk);
    check_eq("idle_no_upd", upd_cnt - base, 32'd0);
    check_eq("idle_sw", sw_state, 32'd0);
    bus_read(CTRL_A, rd);        check_eq("ctrl_rst", rd, 32'h0000_00F1);
    bus_read(32'hFFFF_781A, rd); check_eq("ctrl_alias", rd, 32'h0000_00F1);
    bus_read(EVT_A, rd);         check_eq("evt_rst", rd, 32'd0);
    bus_read(32'h0000_7800, rd); check_eq("rd_other", rd, 32'd0);

    // Switch step
    @(negedge clk);
    base = upd_cnt;
    io_sw = 32'hA5A5_0F0F;
    wait_upd("sw_step", 30, n);
    check_eq("sw_step_val", sw_state, 32'hA5A5_0F0F);
    check_eq("sw_step_latency", 32'(n <= 21), 32'd1);
    repeat (20) @(negedge clk);
    check_eq("sw_step_one_pulse", upd_cnt - base, 32'd1);

    // Short button glitch is rejected
    base = upd_cnt;
    io_btn = 4'b0100;
    repeat (7) @(negedge clk);
    io_btn = 4'b0000;
    repeat (30) @(negedge clk);
    check_eq("glitch_btn", {28'd0, btn_state}, 32'd0);
    check_eq("glitch_no_upd", upd_cnt - base, 32'd0);
    bus_read(EVT_A, rd); check_eq("glitch_evt", rd, 32'd0);

    // Held button: event, irq, W1C
    bus_write(CTRL_A, 32'h0000_00F3);
    io_btn = 4'b0010;
    wait_upd("btn1", 30, n);
    check_eq("btn1_state", {28'd0, btn_state}, 32'h2);
    bus_read(EVT_A, rd); check_eq("btn1_evt", rd, 32'h2);
    @(negedge clk);
    check_eq("btn1_irq", {31'd0, irq}, 32'd1);
    bus_write(EVT_A, 32'h2);
    bus_read(EVT_A, rd); check_eq("w1c_evt", rd, 32'd0);
    @(negedge clk);
    check_eq("w1c_irq", {31'd0, irq}, 32'd0);

    // Release (no event on fall), then clear in the same cycle as the new set
    io_btn = 4'b0000;
    wait_upd("btn1_rel", 30, n);
    check_eq("btn1_rel_state", {28'd0, btn_state}, 32'd0);
    bus_read(EVT_A, rd); check_eq("btn1_rel_evt", rd, 32'd0);
    io_btn = 4'b0010;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (upd_en) begin
        seen = 1'b1;
        bus.i_lsu_wren = 1'b0;
      end else if (dbg_state == S_COMMIT) begin
        bus.i_lsu_addr = EVT_A;
        bus.i_st_data  = 32'h2;
        bus.i_lsu_wren = 1'b1;
      end else begin
        bus.i_lsu_wren = 1'b0;
      end
    end
    bus.i_lsu_wren = 1'b0;
    check_eq("setclr_strobe", 32'(seen), 32'd1);
    bus_read(EVT_A, rd); check_eq("setclr_evt", rd, 32'h2);

    // Scanning disabled: no strobe, state retained
    bus_write(CTRL_A, 32'h0);
    base = upd_cnt;
    io_sw = 32'h0000_FFFF;
    repeat (40) @(negedge clk);
    check_eq("dis_no_upd", upd_cnt - base, 32'd0);
    check_eq("dis_sw", sw_state, 32'hA5A5_0F0F);
    check_eq("dis_fsm", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check_eq("dis_irq", {31'd0, irq}, 32'd0);
    bus_write(CTRL_A, 32'h1);
    wait_upd("en_sw", 30, n);
    check_eq("en_sw_val", sw_state, 32'h0000_FFFF);
    @(negedge clk);
    check_eq("en_irq_off", {31'd0, irq}, 32'd0);
    bus_read(CTRL_A, rd); check_eq("ctrl_1", rd, 32'h1);
    bus_write(CTRL_A, 32'hFFFF_FFFF);
    bus_read(CTRL_A, rd); check_eq("ctrl_mask", rd, 32'h0000_00F3);
    @(negedge clk);
    check_eq("irq_on", {31'd0, irq}, 32'd1);
    bus_write(CTRL_A, 32'h3);
    @(negedge clk);
    check_eq("irq_masked", {31'd0, irq}, 32'd0);

    // Reset in the SAMPLE cycle that would flip
    io_sw  = 32'h1234_5678;
    io_btn = 4'b0000;
    ns = 0;
    for (int k = 1; k <= 60 && ns < 3; k++) begin
      @(negedge clk);
      if (k >= 2 && dbg_state == S_SAMPLE) begin
        ns++;
        if (ns == 3) rst = 1'b0;
      end
    end
    check_eq("mid_rst_found", 32'(ns), 32'd3);
    base = upd_cnt;
    @(negedge clk);
    rst = 1'b1;
    check_eq("mid_rst_upd", {31'd0, upd_en}, 32'd0);
    check_eq("mid_rst_sw", sw_state, 32'd0);
    check_eq("mid_rst_fsm", {30'd0, dbg_state}, {30'd0, S_WAIT});
    repeat (5) @(negedge clk);
    check_eq("mid_rst_no_upd", upd_cnt - base, 32'd0);
    wait_upd("post_rst", 30, n);
    check_eq("post_rst_sw", sw_state, 32'h1234_5678);

    repeat (3) @(negedge clk);
    check_eq("no_consec_upd", 32'(consec), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
